// File: rtl/amstrad_ga_io_decoder.sv
// Z80 I/O write decoder for the gate-array/PAL registers (ram_config, mrer,
// rom_select, pen_sel) plus the Plus-mode RMR2 register and ASIC unlock sequencer.
module amstrad_ga_io_decoder #(
    parameter int unsigned UNLOCK_LEN = 17
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        io_WR,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic        ram64k,
    input  logic        plus_en,
    output logic [7:0]  ram_config,
    output logic [7:0]  mrer,
    output logic [7:0]  rom_select,
    output logic [7:0]  rmr2,
    output logic [4:0]  pen_sel,
    output logic        asic_unlocked,
    output logic        cfg_stb
);

    localparam logic [4:0] IDX_LAST = 5'(UNLOCK_LEN - 1);

    function automatic logic [7:0] seq_byte(input logic [4:0] i);
        logic [7:0] b;
        case (i)
            5'd0:    b = 8'hFF;
            5'd1:    b = 8'h00;
            5'd2:    b = 8'hFF;
            5'd3:    b = 8'h77;
            5'd4:    b = 8'hB3;
            5'd5:    b = 8'h51;
            5'd6:    b = 8'hA8;
            5'd7:    b = 8'hD4;
            5'd8:    b = 8'h62;
            5'd9:    b = 8'h39;
            5'd10:   b = 8'h9C;
            5'd11:   b = 8'h46;
            5'd12:   b = 8'h2B;
            5'd13:   b = 8'h15;
            5'd14:   b = 8'h8A;
            5'd15:   b = 8'hCD;
            5'd16:   b = 8'hEE;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic       r_old_wr;
    logic [7:0] r_ram_config;
    logic [7:0] r_mrer;
    logic [7:0] r_rom_select;
    logic [7:0] r_rmr2;
    logic [4:0] r_pen_sel;
    logic       r_unlocked;
    logic [4:0] r_idx;
    logic       r_cfg_stb;

    logic       w_wr;
    logic       w_ga;
    logic       w_rom;
    logic       w_crtc;
    logic       w_rmr2_sel;
    logic       w_ld_pen;
    logic       w_ld_mrer;
    logic       w_ld_rmr2;
    logic       w_ld_ram;
    logic       w_any_ld;
    logic [4:0] w_idx_nx;
    logic       w_unlocked_nx;
    logic       w_unused;

    assign w_unused = &{1'b0, A[12:10], A[7:0]};

    // Partial decode: several selects may hit in one write and all apply.
    assign w_wr       = io_WR & ~r_old_wr;
    assign w_ga       = w_wr & ~A[15] & A[14];
    assign w_rom      = w_wr & ~A[13];
    assign w_crtc     = w_wr & ~A[14] & (A[9:8] == 2'b00);
    assign w_rmr2_sel = plus_en & r_unlocked & D[5];

    assign w_ld_pen  = w_ga & (D[7:6] == 2'b00);
    assign w_ld_rmr2 = w_ga & (D[7:6] == 2'b10) & w_rmr2_sel;
    assign w_ld_mrer = w_ga & (D[7:6] == 2'b10) & ~w_rmr2_sel;
    assign w_ld_ram  = w_ga & (D[7:6] == 2'b11) & ~ram64k;
    assign w_any_ld  = w_ld_pen | w_ld_rmr2 | w_ld_mrer | w_ld_ram | w_rom;

    always_comb begin
        w_idx_nx      = r_idx;
        w_unlocked_nx = r_unlocked;
        if (!plus_en) begin
            w_idx_nx      = '0;
            w_unlocked_nx = 1'b0;
        end else if (w_crtc) begin
            if (r_idx == IDX_LAST) begin
                w_idx_nx      = '0;
                w_unlocked_nx = (D == seq_byte(IDX_LAST));
            end else if (D == seq_byte(r_idx)) begin
                w_idx_nx = r_idx + 5'd1;
            end else begin
                // A stray FF may itself be the start of a fresh sequence.
                w_idx_nx = (D == 8'hFF) ? 5'd1 : 5'd0;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_old_wr     <= 1'b0;
            r_ram_config <= '0;
            r_mrer       <= '0;
            r_rom_select <= '0;
            r_rmr2       <= '0;
            r_pen_sel    <= '0;
            r_unlocked   <= 1'b0;
            r_idx        <= '0;
            r_cfg_stb    <= 1'b0;
        end else begin
            r_old_wr   <= io_WR;
            r_cfg_stb  <= w_any_ld;
            r_idx      <= w_idx_nx;
            r_unlocked <= w_unlocked_nx;
            if (w_ld_pen)  r_pen_sel    <= D[4:0];
            if (w_ld_mrer) r_mrer       <= D;
            if (w_ld_rmr2) r_rmr2       <= D;
            if (w_ld_ram)  r_ram_config <= D;
            if (w_rom)     r_rom_select <= D;
        end
    end

    assign ram_config    = r_ram_config;
    assign mrer          = r_mrer;
    assign rom_select    = r_rom_select;
    assign rmr2          = r_rmr2;
    assign pen_sel       = r_pen_sel;
    assign asic_unlocked = r_unlocked;
    assign cfg_stb       = r_cfg_stb;

endmodule
